vram_arbiter: RTL and testbench

//  Shares one single-port synchronous video RAM bank (RB or GG plane) between the video fetcher and
//  the Z80. The video fetcher has absolute priority and fixed latency; CPU accesses fill idle slots
//  and are completed with a req/ack handshake. Sits between the lynx48 top, the video block and one
//  spr-style RAM instance, replacing the dpr second port.

---
 rtl/lynx_vram_pkg.sv | 21 ++
 rtl/vram_arb_stats.sv | 26 ++
 rtl/vram_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_vram_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lynx_vram_pkg.sv
// rtl/lynx_vram_pkg.sv - slot tags, CPU FSM states and video latency shared by the VRAM arbiter
package lynx_vram_pkg;

    typedef enum logic [1:0] {
        SLOT_IDLE = 2'd0,
        SLOT_VID  = 2'd1,
        SLOT_CPU  = 2'd2
    } slot_t;

    typedef enum logic [2:0] {
        C_IDLE  = 3'd0,
        C_PEND  = 3'd1,
        C_ISSUE = 3'd2,
        C_WAIT  = 3'd3,
        C_ACK   = 3'd4
    } cpu_state_t;

    // Edges from vid_req sampled to vid_valid asserted
    localparam int VID_LATENCY = 3;

endpackage

// File: rtl/vram_arb_stats.sv
// rtl/vram_arb_stats.sv - saturating CPU stall-cycle counter, cleared only by reset
module vram_arb_stats #(
    parameter int SCW = 16
) (
    input  logic           i_clock,
    input  logic           i_reset,
    input  logic           i_inc,
    output logic [SCW-1:0] o_count
);

    localparam logic [SCW-1:0] ONE = {{(SCW-1){1'b0}}, 1'b1};

    logic [SCW-1:0] r_count;

    // Count stalled edges, holding at all-ones instead of wrapping
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + ONE;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM sharing between video fetch and Z80 (stall counter under VRAM_ARB_STATS_EN)
module vram_arbiter
    import lynx_vram_pkg::*;
#(
    parameter int AW  = 14,
    parameter int DW  = 8,
    parameter int SCW = 16
) (
    input  logic           i_clock,
    input  logic           i_reset,
    input  logic           i_vid_req,
    input  logic [AW-1:0]  i_vid_a,
    output logic [DW-1:0]  o_vid_q,
    output logic           o_vid_valid,
    input  logic           i_cpu_req,
    input  logic           i_cpu_we,
    input  logic [AW-1:0]  i_cpu_a,
    input  logic [DW-1:0]  i_cpu_d,
    output logic [DW-1:0]  o_cpu_q,
    output logic           o_cpu_ack,
    output logic [AW-1:0]  o_mem_a,
    output logic           o_mem_we,
    output logic [DW-1:0]  o_mem_d,
    input  logic [DW-1:0]  i_mem_q,
    output logic [SCW-1:0] o_stall_cnt
);

    // Slot chosen at the sampling edge, with the access it carries
    slot_t         r_sel;
    logic [AW-1:0] r_sel_a;
    logic          r_sel_we;
    logic [DW-1:0] r_sel_d;

    // Tag of the slot on the RAM port (stage 1) and of the slot whose data is on mem_q (stage 2)
    slot_t         r_tag1;
    slot_t         r_tag2;

    // RAM port and result registers
    logic [AW-1:0] r_mem_a;
    logic          r_mem_we;
    logic [DW-1:0] r_mem_d;
    logic [DW-1:0] r_vid_q;
    logic          r_vid_valid;
    logic [DW-1:0] r_cpu_q;
    logic          r_cpu_ack;
    logic          r_cpu_we;

    cpu_state_t    r_state;
    cpu_state_t    w_state_nxt;
    slot_t         w_slot_nxt;
    logic          w_cpu_done;

    // The CPU access has reached the capture stage; only one CPU access is ever in flight
    assign w_cpu_done = (r_state == C_WAIT) && (r_tag2 == SLOT_CPU);

    // Slot selection: video always wins, a pending CPU access takes an otherwise idle slot
    always_comb begin
        w_slot_nxt = SLOT_IDLE;
        if (i_vid_req) begin
            w_slot_nxt = SLOT_VID;
        end else if (r_state == C_PEND) begin
            w_slot_nxt = SLOT_CPU;
        end
    end

    // CPU FSM next state; C_ACK always returns to C_IDLE so a held cpu_req is not re-taken there
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            C_IDLE:  if (i_cpu_req) w_state_nxt = C_PEND;
            C_PEND:  if (!i_vid_req) w_state_nxt = C_ISSUE;
            C_ISSUE: w_state_nxt = C_WAIT;
            C_WAIT:  if (w_cpu_done) w_state_nxt = C_ACK;
            C_ACK:   w_state_nxt = C_IDLE;
            default: w_state_nxt = C_IDLE;
        endcase
    end

    // CPU FSM state register; reset drops any pending or in-flight CPU access
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= C_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Stage 0: latch the granted access (in C_ISSUE this holds cpu_a/cpu_we/cpu_d for the RAM port)
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_sel    <= SLOT_IDLE;
            r_sel_a  <= '0;
            r_sel_we <= 1'b0;
            r_sel_d  <= '0;
            r_cpu_we <= 1'b0;
        end else begin
            r_sel <= w_slot_nxt;
            if (w_slot_nxt == SLOT_VID) begin
                r_sel_a  <= i_vid_a;
                r_sel_we <= 1'b0;
            end else if (w_slot_nxt == SLOT_CPU) begin
                r_sel_a  <= i_cpu_a;
                r_sel_we <= i_cpu_we;
                r_sel_d  <= i_cpu_d;
                r_cpu_we <= i_cpu_we;
            end else begin
                r_sel_we <= 1'b0;
            end
        end
    end

    // Stage 1: drive the RAM port; idle slots keep the address and never write
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_tag1   <= SLOT_IDLE;
            r_mem_a  <= '0;
            r_mem_we <= 1'b0;
            r_mem_d  <= '0;
        end else begin
            r_tag1 <= r_sel;
            if (r_sel != SLOT_IDLE) begin
                r_mem_a  <= r_sel_a;
                r_mem_we <= r_sel_we;
                r_mem_d  <= r_sel_d;
            end else begin
                r_mem_we <= 1'b0;
            end
        end
    end

    // Stage 2 tag follows the RAM's registered read
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_tag2 <= SLOT_IDLE;
        end else begin
            r_tag2 <= r_tag1;
        end
    end

    // Stage 3: hand mem_q to its owner; CPU writes acknowledge without touching cpu_q
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_vid_q     <= '0;
            r_vid_valid <= 1'b0;
            r_cpu_q     <= '0;
            r_cpu_ack   <= 1'b0;
        end else begin
            r_vid_valid <= (r_tag2 == SLOT_VID);
            if (r_tag2 == SLOT_VID) begin
                r_vid_q <= i_mem_q;
            end
            r_cpu_ack <= w_cpu_done;
            if (w_cpu_done && !r_cpu_we) begin
                r_cpu_q <= i_mem_q;
            end
        end
    end

    assign o_mem_a     = r_mem_a;
    assign o_mem_we    = r_mem_we;
    assign o_mem_d     = r_mem_d;
    assign o_vid_q     = r_vid_q;
    assign o_vid_valid = r_vid_valid;
    assign o_cpu_q     = r_cpu_q;
    assign o_cpu_ack   = r_cpu_ack;

`ifdef VRAM_ARB_STATS_EN
    logic w_stall_inc;

    // A pending CPU access loses this edge's slot to video
    assign w_stall_inc = (r_state == C_PEND) && i_vid_req;

    vram_arb_stats #(
        .SCW (SCW)
    ) u_stats (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_inc   (w_stall_inc),
        .o_count (o_stall_cnt)
    );
`else
    assign o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - directed self-checking bench for vram_arbiter with a behavioural single-port RAM
module tb_vram_arbiter;

    localparam int AW  = 14;
    localparam int DW  = 8;
    localparam int SCW = 16;

    logic           clk;
    logic           rst_n;
    logic           vid_req;
    logic [AW-1:0]  vid_a;
    logic [DW-1:0]  vid_q;
    logic           vid_valid;
    logic           cpu_req;
    logic           cpu_we;
    logic [AW-1:0]  cpu_a;
    logic [DW-1:0]  cpu_d;
    logic [DW-1:0]  cpu_q;
    logic           cpu_ack;
    logic [AW-1:0]  mem_a;
    logic           mem_we;
    logic [DW-1:0]  mem_d;
    logic [DW-1:0]  mem_q;
    logic [SCW-1:0] stall_cnt;

    logic           pre_we;
    logic [AW-1:0]  pre_a;
    logic [DW-1:0]  pre_d;
    logic [DW-1:0]  ram [0:(1<<AW)-1];

    int n_checks;
    int n_errors;

    vram_arbiter #(.AW(AW), .DW(DW), .SCW(SCW)) dut (
        .i_clock     (clk),
        .i_reset     (rst_n),
        .i_vid_req   (vid_req),
        .i_vid_a     (vid_a),
        .o_vid_q     (vid_q),
        .o_vid_valid (vid_valid),
        .i_cpu_req   (cpu_req),
        .i_cpu_we    (cpu_we),
        .i_cpu_a     (cpu_a),
        .i_cpu_d     (cpu_d),
        .o_cpu_q     (cpu_q),
        .o_cpu_ack   (cpu_ack),
        .o_mem_a     (mem_a),
        .o_mem_we    (mem_we),
        .o_mem_d     (mem_d),
        .i_mem_q     (mem_q),
        .o_stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous RAM; pre_we is a bench-only backdoor for preloading
    always @(posedge clk) begin
        if (pre_we) begin
            ram[pre_a] <= pre_d;
        end else if (mem_we) begin
            ram[mem_a] <= mem_d;
        end
        mem_q <= ram[mem_a];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_we = 1'b1;
        pre_a  = a;
        pre_d  = d;
        tick();
        pre_we = 1'b0;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        cpu_req = 1'b1;
        cpu_we  = 1'b1;
        cpu_a   = 14'h0abc;
        cpu_d   = 8'hff;
        vid_req = 1'b1;
        vid_a   = 14'h0123;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++;
            if ({vid_valid, cpu_ack, mem_we} !== 3'b000) begin
                n_errors++;
                $display("FAIL reset_strobes cycle %0d got %b want 000", k, {vid_valid, cpu_ack, mem_we});
            end
            n_checks++;
            if ({mem_a, mem_d, vid_q, cpu_q, stall_cnt} !== '0) begin
                n_errors++;
                $display("FAIL reset_data cycle %0d mem_a=%h mem_d=%h vid_q=%h cpu_q=%h stall=%0d want all 0",
                         k, mem_a, mem_d, vid_q, cpu_q, stall_cnt);
            end
        end
        cpu_req = 1'b0;
        vid_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++;
        if ({vid_valid, cpu_ack, mem_we} !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_release got %b want 000", {vid_valid, cpu_ack, mem_we});
        end
    endtask

    task automatic test_video_only();
        logic [DW-1:0] exp_q [0:2];
        exp_q[0] = 8'hA5;
        exp_q[1] = 8'h5A;
        exp_q[2] = 8'h3C;
        preload(14'h0010, 8'hA5);
        preload(14'h0011, 8'h5A);
        preload(14'h0012, 8'h3C);
        tick();
        // vid_req sampled at edges 0,1,2; results after edges 3,4,5
        for (int k = 0; k <= 6; k++) begin
            vid_req = (k <= 2);
            vid_a   = 14'h0010 + 14'(k);
            tick();
            n_checks++;
            if (vid_valid !== (k >= 3 && k <= 5)) begin
                n_errors++;
                $display("FAIL video_valid edge %0d got %b want %b", k, vid_valid, (k >= 3 && k <= 5));
            end
            if (k >= 3 && k <= 5) begin
                n_checks++;
                if (vid_q !== exp_q[k-3]) begin
                    n_errors++;
                    $display("FAIL video_data edge %0d got %h want %h", k, vid_q, exp_q[k-3]);
                end
            end
        end
        vid_req = 1'b0;
    endtask

    task automatic cpu_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic [DW-1:0] exp_q, input string name);
        cpu_req = 1'b1;
        cpu_we  = we;
        cpu_a   = a;
        cpu_d   = d;
        for (int k = 0; k <= 4; k++) begin
            tick();
            n_checks++;
            if (cpu_ack !== (k == 4)) begin
                n_errors++;
                $display("FAIL %s_ack edge %0d got %b want %b", name, k, cpu_ack, (k == 4));
            end
            if (k == 2) begin
                n_checks++;
                if ({mem_we, mem_a} !== {we, a}) begin
                    n_errors++;
                    $display("FAIL %s_port edge 2 got we=%b a=%h want we=%b a=%h", name, mem_we, mem_a, we, a);
                end
            end
        end
        n_checks++;
        if (cpu_q !== exp_q) begin
            n_errors++;
            $display("FAIL %s_q got %h want %h", name, cpu_q, exp_q);
        end
        cpu_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_cpu_write_read();
        // cpu_q still holds its reset value across the write
        cpu_access(1'b1, 14'h1234, 8'h77, 8'h00, "cpu_write");
        cpu_access(1'b0, 14'h1234, 8'h00, 8'h77, "cpu_read");
    endtask

    task automatic test_contention();
        // Request and video on edge 0, video continues through edge 6: grant at 7, ack at 10
        cpu_req = 1'b1;
        cpu_we  = 1'b0;
        cpu_a   = 14'h0010;
        for (int k = 0; k <= 10; k++) begin
            vid_req = (k <= 6);
            vid_a   = 14'h0011;
            tick();
            n_checks++;
            if (cpu_ack !== (k == 10)) begin
                n_errors++;
                $display("FAIL contention_ack edge %0d got %b want %b", k, cpu_ack, (k == 10));
            end
        end
        n_checks++;
        if (cpu_q !== 8'hA5) begin
            n_errors++;
            $display("FAIL contention_q got %h want a5", cpu_q);
        end
        n_checks++;
`ifdef VRAM_ARB_STATS_EN
        if (stall_cnt !== 16'd6) begin
            n_errors++;
            $display("FAIL stall_cnt got %0d want 6", stall_cnt);
        end
`else
        if (stall_cnt !== 16'd0) begin
            n_errors++;
            $display("FAIL stall_cnt got %0d want 0", stall_cnt);
        end
`endif
        cpu_req = 1'b0;
        vid_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_write_then_vid();
        preload(14'h0100, 8'h11);
        tick();
        cpu_req = 1'b1;
        cpu_we  = 1'b1;
        cpu_a   = 14'h0100;
        cpu_d   = 8'hC3;
        tick();
        tick();
        // CPU slot granted at edge 1; video read of the same address sampled at edge 2
        for (int k = 2; k <= 6; k++) begin
            vid_req = (k == 2);
            vid_a   = 14'h0100;
            tick();
            if (k == 4) begin
                n_checks++;
                if (cpu_ack !== 1'b1) begin
                    n_errors++;
                    $display("FAIL raw_cpu_ack got %b want 1", cpu_ack);
                end
                cpu_req = 1'b0;
            end
            n_checks++;
            if (vid_valid !== (k == 5)) begin
                n_errors++;
                $display("FAIL raw_vid_valid edge %0d got %b want %b", k, vid_valid, (k == 5));
            end
            if (k == 5) begin
                n_checks++;
                if (vid_q !== 8'hC3) begin
                    n_errors++;
                    $display("FAIL raw_vid_q got %h want c3", vid_q);
                end
            end
        end
        vid_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_access();
        cpu_req = 1'b1;
        cpu_we  = 1'b0;
        cpu_a   = 14'h1234;
        tick();
        tick();
        tick();
        // FSM is in C_WAIT here
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if ({cpu_ack, cpu_q} !== 9'd0) begin
                n_errors++;
                $display("FAIL midreset_hold cycle %0d got ack=%b q=%h want 0/00", k, cpu_ack, cpu_q);
            end
        end
        rst_n = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            tick();
            n_checks++;
            if (cpu_ack !== (k == 4)) begin
                n_errors++;
                $display("FAIL midreset_ack edge %0d got %b want %b", k, cpu_ack, (k == 4));
            end
        end
        n_checks++;
        if (cpu_q !== 8'h77) begin
            n_errors++;
            $display("FAIL midreset_q got %h want 77", cpu_q);
        end
        cpu_req = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        pre_we   = 1'b0;
        pre_a    = '0;
        pre_d    = '0;
        rst_n    = 1'b0;
        vid_req  = 1'b0;
        vid_a    = '0;
        cpu_req  = 1'b0;
        cpu_we   = 1'b0;
        cpu_a    = '0;
        cpu_d    = '0;
        test_reset();
        test_video_only();
        test_cpu_write_read();
        test_contention();
        test_write_then_vid();
        test_reset_mid_access();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
